// File: rtl/core_pkg.sv
// Shared definitions for the Fibonacci RV32 core: sequencer states, opcodes,
// error codes, immediate-select encodings and the halt instruction.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_ILLEGAL    = 2'd1,
    ERR_TIMEOUT    = 2'd2,
    ERR_MISALIGNED = 2'd3
  } err_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] OPC_J = 7'b1101111;

  // immrd select values consumed by the immediate generator
  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_B = 2'd1;
  localparam logic [1:0] IMM_J = 2'd2;

  // jal x0,0 : a self-loop, treated as a clean stop
  localparam logic [31:0] HALT_INSTR = 32'h0000_006F;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OPC_R) || (op == OPC_I) || (op == OPC_B) || (op == OPC_J);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction-memory fetch port of the core sequencer.
// Handshake: imem_req rises in FETCH and stays high with imem_addr stable until
// a cycle in which imem_ack is high; that cycle transfers imem_rdata. An ack
// while imem_req is low is ignored.
interface core_sequencer_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/core_next_pc.sv
// Combinational next-PC selection: JAL and taken bne jump by the immediate,
// everything else falls through to pc+4. Flags a non-word-aligned result.
module core_next_pc
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [6:0]      opcode,
  input  logic            branch,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic take;

  always_comb begin
    // only bne is supported, so a branch is taken when operands differ
    take       = (opcode == OPC_J) || ((opcode == OPC_B) && branch && !zero);
    next_pc    = take ? (pc + imm) : (pc + XLEN'(4));
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer: owns pc, ir and the
// retired counter, drives instruction fetch and gates rf/pc write strobes.
module core_sequencer
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  core_sequencer_if.master imem,
  output logic [XLEN-1:0] ir_o,
  input  logic            regwrite_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            alu_zero_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            rf_we,
  output logic            busy,
  output logic            halted,
  output logic [1:0]      err_code,
  output logic [31:0]     retired,
  output state_e          dbg_state
);

  // wait counter holds 0..TIMEOUT-1; reaching TIMEOUT-1 without ack times out
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  err_e            err_q, err_d;
  logic [31:0]     ret_q, ret_d;
  logic            rw_q, rw_d;

  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  core_next_pc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .pc        (pc_q),
    .imm       (imm_i),
    .opcode    (ir_q[6:0]),
    .branch    (branch_i),
    .zero      (alu_zero_i),
    .next_pc   (next_pc),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      npc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      ret_q   <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    npc_d   = npc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ret_d   = ret_q;
    rw_d    = rw_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          cnt_d   = '0;
          state_d = ST_DECODE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          cnt_d   = '0;
          state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DECODE: begin
        if (!opcode_legal(ir_q[6:0])) begin
          err_d   = ERR_ILLEGAL;
          state_d = ST_HALT;
        end else if (ir_q == XLEN'(HALT_INSTR)) begin
          err_d   = ERR_NONE;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (misaligned) begin
          err_d   = ERR_MISALIGNED;
          state_d = ST_HALT;
        end else begin
          // regwrite is settled since DECODE; capturing it keeps rf_we a pure flop output
          npc_d   = next_pc;
          rw_d    = regwrite_i;
          state_d = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        pc_d    = npc_q;
        ret_d   = ret_q + 32'd1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          err_d   = ERR_NONE;
          pc_d    = RESET_PC;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;

  assign ir_o       = ir_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + XLEN'(4);
  assign rf_we      = (state_q == ST_WRITEBACK) && rw_q;
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);
  assign halted     = (state_q == ST_HALT);
  assign err_code   = err_q;
  assign retired    = ret_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: the bench plays instruction memory and control unit,
// predicts fetch/writeback/halt events from the ISA rules and checks them as they occur.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int          XLEN = 32;
  localparam int          TO   = 4;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int          W    = 80;
  localparam logic [1:0]  K_FETCH = 2'd1;
  localparam logic [1:0]  K_WB    = 2'd2;
  localparam logic [1:0]  K_HALT  = 2'd3;
  localparam logic [31:0] ADDI    = 32'h0010_0093;
  localparam logic [31:0] BNE     = 32'h0020_9463;
  localparam logic [31:0] HALTW   = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        regwrite_i = 1'b0;
  logic        branch_i = 1'b0;
  logic        alu_zero_i = 1'b0;
  logic [31:0] imm_i = '0;
  logic [31:0] ir_o, pc_o, pc_plus4_o, retired;
  logic        rf_we, busy, halted;
  logic [1:0]  err_code;
  state_e      dbg_state;

  core_sequencer_if #(.XLEN(XLEN)) imem ();

  core_sequencer #(.XLEN(XLEN), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem(imem), .ir_o(ir_o),
    .regwrite_i(regwrite_i), .branch_i(branch_i), .imm_i(imm_i), .alu_zero_i(alu_zero_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .rf_we(rf_we), .busy(busy), .halted(halted),
    .err_code(err_code), .retired(retired), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic [1:0] k, input logic [1:0] err, input logic rfwe,
                                       input logic [7:0] lat, input logic [31:0] a, input logic [31:0] b);
    return {k, err, rfwe, 3'b000, lat, a, b};
  endfunction

  int fetch_cyc = 0;

  task automatic handle(input logic [1:0] k);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 32'(k), 32'(e[79:78]));
    if (e[79:78] != k) return;
    case (k)
      K_FETCH: begin
        check("fetch_addr", imem.imem_addr, e[63:32]);
        check("fetch_pc", pc_o, e[63:32]);
        check("fetch_err", 32'(err_code), 32'(e[77:76]));
        check("fetch_retired", retired, e[31:0]);
        fetch_cyc = cyc;
      end
      K_WB: begin
        check("wb_rf_we", 32'(rf_we), 32'(e[75]));
        check("wb_pc_plus4", pc_plus4_o, e[63:32]);
        check("wb_retired", retired, e[31:0]);
        check("wb_latency", 32'(cyc - fetch_cyc), 32'(e[71:64]));
      end
      default: begin
        check("halt_err", 32'(err_code), 32'(e[77:76]));
        check("halt_pc", pc_o, e[63:32]);
        check("halt_retired", retired, e[31:0]);
      end
    endcase
  endtask

  // monitor: samples on the falling edge, away from the active edge
  logic prev_req = 1'b0;
  logic prev_halt = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req  = 1'b0;
      prev_halt = 1'b0;
    end else begin
      if (imem.imem_req && !prev_req) handle(K_FETCH);
      if (dbg_state == ST_WRITEBACK) handle(K_WB);
      if (halted && !prev_halt) handle(K_HALT);
      if (rf_we && dbg_state != ST_WRITEBACK) begin
        checks++;
        errors++;
        $display("FAIL stray_rf_we: got 1 outside writeback expected 0");
      end
      prev_req  = imem.imem_req;
      prev_halt = halted;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_pc  = RPC;
  logic [31:0] m_ret = '0;

  function automatic bit legal_op(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h63 || op == 7'h6F;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL wait_halt: got halted=0 expected halted=1 within 20 cycles");
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_pc = RPC;
    check("req_after_start", 32'(imem.imem_req), 32'd1);
  endtask

  task automatic run_instr(input logic [31:0] word, input logic [31:0] imm, input logic rw,
                           input logic br, input logic z, input int delay, input bit poke,
                           output bit will_halt);
    logic [6:0]  op;
    logic [31:0] tgt;
    logic [1:0]  herr;
    bit          reach;
    int          n;
    op = word[6:0];
    tgt = m_pc + 32'd4;
    herr = ERR_NONE;
    will_halt = 1'b1;
    reach = 1'b0;
    exp_q.push_back(rec(K_FETCH, ERR_NONE, 1'b0, 8'd0, m_pc, m_ret));
    if (delay >= TO) herr = ERR_TIMEOUT;
    else if (!legal_op(op)) herr = ERR_ILLEGAL;
    else if (word == HALTW) herr = ERR_NONE;
    else begin
      reach = 1'b1;
      if (op == 7'h6F || (op == 7'h63 && br && !z)) tgt = m_pc + imm;
      if (tgt[1:0] != 2'b00) herr = ERR_MISALIGNED;
      else will_halt = 1'b0;
    end
    if (will_halt) exp_q.push_back(rec(K_HALT, herr, 1'b0, 8'd0, m_pc, m_ret));
    else begin
      exp_q.push_back(rec(K_WB, ERR_NONE, rw, 8'(delay + 3), m_pc + 32'd4, m_ret));
      m_pc = tgt;
      m_ret = m_ret + 32'd1;
    end

    n = 0;
    while (!imem.imem_req && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem.imem_req) begin
      checks++;
      errors++;
      $display("FAIL wait_fetch: got imem_req=0 expected 1 within 100 cycles");
      return;
    end
    if (delay < TO) begin
      repeat (delay) begin
        @(posedge clk); #1;
      end
      imem.imem_ack = 1'b1;
      imem.imem_rdata = word;
      imm_i = imm;
      regwrite_i = rw;
      branch_i = br;
      alu_zero_i = z;
      @(posedge clk); #1;
      if (poke && reach) begin
        // a late ack during DECODE and start during EXECUTE must both be ignored
        imem.imem_rdata = ~word;
        @(posedge clk); #1;
        imem.imem_ack = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      imem.imem_ack = 1'b0;
      imem.imem_rdata = $urandom();
    end
    if (will_halt) wait_halt();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit h;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_pc", pc_o, RPC);
    check("rst_ir", ir_o, 32'd0);
    check("rst_pc_plus4", pc_plus4_o, RPC + 32'd4);
    check("rst_req", 32'(imem.imem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    check("rst_retired", retired, 32'd0);
    @(posedge clk); #1;
    check("idle_no_req", 32'(imem.imem_req), 32'd0);

    // directed program
    do_start();
    run_instr(ADDI, 32'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    run_instr(ADDI, 32'd1, 1'b1, 1'b0, 1'b0, 1, 1'b0, h);
    run_instr(ADDI, 32'd1, 1'b1, 1'b0, 1'b0, 2, 1'b0, h);
    run_instr(ADDI, 32'd1, 1'b1, 1'b0, 1'b0, TO - 1, 1'b1, h);
    run_instr(BNE, 32'd8, 1'b0, 1'b1, 1'b1, 0, 1'b0, h);
    run_instr(32'hFFDF_F06F, -32'sd4, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    run_instr(BNE, 32'd8, 1'b0, 1'b1, 1'b0, 0, 1'b0, h);
    run_instr(32'h0080_006F, 32'd8, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    run_instr(32'hFF9F_F0EF, -32'sd8, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    run_instr(HALTW, 32'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    do_start();
    run_instr(ADDI, 32'd1, 1'b1, 1'b0, 1'b0, TO, 1'b0, h);
    do_start();
    run_instr(32'h0000_0003, 32'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    do_start();
    run_instr(32'h0000_00EF, 32'd2, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    do_start();

    // randomized program
    for (int i = 0; i < 60; i++) begin
      logic [31:0] r, word, imm;
      logic [6:0]  op;
      int          sel, d, v;
      sel = int'($urandom_range(0, 19));
      r = $urandom();
      if (sel < 4) op = 7'h33;
      else if (sel < 8) op = 7'h13;
      else if (sel < 12) op = 7'h63;
      else if (sel < 16) op = 7'h6F;
      else if (sel == 16) begin
        op = 7'($urandom());
        if (legal_op(op)) op = 7'h03;
      end else op = 7'h13;
      word = {r[31:7], op};
      if (sel == 17) word = HALTW;
      v = int'($urandom_range(0, 63)) - 32;
      imm = 32'(v * 4);
      if ($urandom_range(0, 15) == 0) imm = imm + 32'd2;
      d = int'($urandom_range(0, 9));
      d = (d == 9) ? TO : (d % TO);
      run_instr(word, imm, 1'($urandom()), 1'($urandom()), 1'($urandom()), d,
                $urandom_range(0, 7) == 0, h);
      if (h) do_start();
    end
    run_instr(HALTW, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, h);

    // reset while a fetch is waiting for ack
    do_start();
    exp_q.push_back(rec(K_FETCH, ERR_NONE, 1'b0, 8'd0, m_pc, m_ret));
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midfetch_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midfetch_rst_req", 32'(imem.imem_req), 32'd0);
    check("midfetch_rst_retired", retired, 32'd0);
    check("midfetch_rst_busy", 32'(busy), 32'd0);
    check("midfetch_rst_pc", pc_o, RPC);
    check("queue_before_rst", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_ret = '0;

    do_start();
    run_instr(ADDI, 32'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0, h);
    run_instr(HALTW, 32'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0, h);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_retired", retired, m_ret);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle fetch/decode/execute/writeback sequencer for the Fibonacci RV32 core. It owns the PC and instruction register and drives the instruction-memory request handshake. It gates the combinational control unit's `regwrite`/`branch` decisions into single-cycle register-file and PC write strobes. It detects halt, illegal-opcode, misaligned-target and fetch-timeout conditions and reports them.

## Interface
Parameters:
- `XLEN`, 32: datapath and instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset and on start.
- `TIMEOUT`, 64: max cycles `imem_req` may wait for `imem_ack`; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin execution at `RESET_PC`; ignored while busy.
- `imem_req` out 1: fetch request, held until ack.
- `imem_addr` out XLEN: fetch address, equals `pc_o` while `imem_req` is high.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in XLEN: instruction word.
- `ir_o` out XLEN: instruction register, feeds the control unit and immediate generator.
- `regwrite_i` in 1: from the control unit.
- `branch_i` in 1: from the control unit.
- `imm_i` in XLEN: sign-extended immediate selected by `immrd`.
- `alu_zero_i` in 1: ALU result equals zero, valid in EXECUTE.
- `pc_o` out XLEN: current PC.
- `pc_plus4_o` out XLEN: `pc_o + 4`, the JAL link value.
- `rf_we` out 1: register-file write strobe, one cycle, WRITEBACK only.
- `busy` out 1: high in FETCH, DECODE, EXECUTE and WRITEBACK.
- `halted` out 1: high in HALT.
- `err_code` out 2: 0 none, 1 illegal opcode, 2 fetch timeout, 3 misaligned target.
- `retired` out 32: count of instructions completing WRITEBACK.

## Operation
States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK and HALT.
- IDLE: `start` moves to FETCH and loads `pc`←`RESET_PC`.
- FETCH:
  - `imem_req`=1 with `imem_addr`=`pc`, and the wait counter increments.
  - On `imem_ack`: `ir`←`imem_rdata`, counter clears, go to DECODE.
  - If the counter reaches `TIMEOUT` without ack: `err_code`=2, go to HALT. Ack on the same cycle the counter reaches `TIMEOUT` wins over the timeout.
- DECODE: one cycle for the control-unit outputs to settle.
  - `ir[6:0]` not in {0110011, 0010011, 1100011, 1101111}: `err_code`=1, go to HALT. `ir` is not retired.
  - `ir` == 32'h0000_006F (`jal x0,0`): go to HALT with `err_code`=0, not retired.
  - Otherwise go to EXECUTE.
- EXECUTE: compute `next_pc`.
  - Opcode 1101111 (JAL): `pc+imm_i`.
  - Opcode 1100011 with `branch_i` and `!alu_zero_i` (bne taken): `pc+imm_i`.
  - Otherwise: `pc+4`.
  - `next_pc[1:0]`≠0: `err_code`=3, go to HALT.
  - Otherwise register `next_pc` and go to WRITEBACK.
- WRITEBACK: `rf_we`=`regwrite_i`, `pc`←`next_pc`, `retired`+1, go to FETCH.
- HALT: `start` clears `err_code`, loads `pc`←`RESET_PC` and goes to FETCH. `retired` is kept. All other inputs are ignored.
- Arithmetic:
  - PC adds are modulo 2^XLEN; wrap is silent.
  - `retired` wraps at 2^32.
- Reset, at any time including mid-fetch: state=IDLE, `pc`=`ir`=`RESET_PC`/0, `imem_req`=0, `rf_we`=0, `busy`=0, `halted`=0, `err_code`=0, `retired`=0, wait counter=0. The `imem_addr` and `pc_plus4_o` reset values follow from `pc`.

## Timing
- Outputs `imem_req`, `rf_we`, `busy` and `halted` are decoded from the registered state, with no combinational path from inputs.
- Latency per instruction is 4 cycles plus W, where W is the number of ack-wait cycles. Ack on the first FETCH cycle gives 4 cycles per instruction.
- The first `imem_req` occurs in the cycle after `start` is sampled.
- Next-PC rules:
  - `rf_we` and the PC update occur on the same edge, in the WRITEBACK cycle.
  - The next `imem_addr` shows the new PC in the following FETCH cycle.
- `imem_ack` outside FETCH is ignored.
- `start` in FETCH through WRITEBACK is ignored.

## Structure
- Shared package `core_pkg` holds:
  - the state enum;
  - the opcode localparams R/I/B/J;
  - the `err_code` enum;
  - the `IMM_I/B/J` encodings;
  - the `HALT_INSTR` constant.
- One sub-module, `core_next_pc`, is combinational. It takes `pc`, `imm`, opcode, `branch` and `zero`, and returns `next_pc` and `misaligned`.
- The sequencer holds the FSM, wait counter, `ir`, `pc` and `retired`.

## Test plan
- Reset, `start`, ack on the first cycle, `ir`=`addi x1,x0,1` (0x00100093). Required: `rf_we` pulses in cycle 4, `pc` goes 0→4, `retired`=1.
- Fetch of 0x00209463 (`bne x1,x2,+8`) at pc=0x10. Required: `next_pc` is 0x18 with `alu_zero_i`=0, and 0x14 with `alu_zero_i`=1. `rf_we`=0 in both cases.
- JAL with `imm_i`=-8 at pc=0x20. Required: `pc`→0x18, `pc_plus4_o`=0x24 during WRITEBACK, `rf_we`=1. Then `ir`=0x0000006F. Required: `halted`=1, `err_code`=0, and `retired` does not increment.
- `imem_ack` withheld for `TIMEOUT`=4 cycles. Required: HALT with `err_code`=2. Then `start`. Required: FETCH at pc=0 with `err_code`=0.
- `ir`=0x00000003 (load opcode). Required: `err_code`=1. Separately, JAL with `imm_i`=2. Required: `err_code`=3, `pc` unchanged.
- `rst` asserted while `imem_req` is waiting. Required: next cycle IDLE, `imem_req`=0, `retired`=0. `start` pulsed mid-EXECUTE. Required: no effect.
